// File: rtl/alarm_ctrl.sv
// Alarm clock controller: seconds/minutes/hours timekeeping, time and alarm
// setting, ring with 60-second timeout, and minute-based snooze.
//
// state     | meaning
// RUN       | normal timekeeping, alarm match armed when alarm_on
// SET_TIME  | time frozen, sec held at 0, adv_min/adv_hr edit time
// SET_ALARM | time runs, adv_min/adv_hr edit alarm time
// RING      | buzzer on, times out after 60 ticks
// SNOOZE    | buzzer off, returns to RING after SNOOZE_MIN minute rollovers
module alarm_ctrl #(
  parameter int HRS        = 24,
  parameter int SNOOZE_MIN = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       adv_min,
  input  logic       adv_hr,
  input  logic       alarm_on,
  input  logic       snooze,
  input  logic       stop,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [6:0] hr,
  output logic [6:0] al_min,
  output logic [6:0] al_hr,
  output logic       buzz,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_TIME  = 3'd1,
    SET_ALARM = 3'd2,
    RING      = 3'd3,
    SNOOZE    = 3'd4
  } state_t;

  localparam logic [6:0] HR_MAX   = 7'(HRS - 1);
  localparam logic [5:0] SNZ_LOAD = 6'(SNOOZE_MIN);

  state_t     st;
  logic [5:0] ring_cnt;
  logic [5:0] snz_cnt;

  logic       sec_wrap, min_wrap, hr_wrap, min_roll, match;
  logic [6:0] sec_nx, min_nx, hr_nx;
  logic [6:0] min_adv, hr_adv, al_min_adv, al_hr_adv;

  assign state = st;

  always_comb begin
    sec_wrap   = (sec == 7'd59);
    min_wrap   = (min == 7'd59);
    hr_wrap    = (hr == HR_MAX);
    min_roll   = tick && sec_wrap;
    sec_nx     = tick ? (sec_wrap ? 7'd0 : sec + 7'd1) : sec;
    min_nx     = min_roll ? (min_wrap ? 7'd0 : min + 7'd1) : min;
    hr_nx      = (min_roll && min_wrap) ? (hr_wrap ? 7'd0 : hr + 7'd1) : hr;
    // Match is judged on the post-tick time so RING starts with the update.
    match      = alarm_on && tick && (sec_nx == 7'd0) &&
                 (min_nx == al_min) && (hr_nx == al_hr);
    min_adv    = adv_min ? (min_wrap ? 7'd0 : min + 7'd1) : min;
    hr_adv     = adv_hr ? (hr_wrap ? 7'd0 : hr + 7'd1) : hr;
    al_min_adv = adv_min ? ((al_min == 7'd59) ? 7'd0 : al_min + 7'd1) : al_min;
    al_hr_adv  = adv_hr ? ((al_hr == HR_MAX) ? 7'd0 : al_hr + 7'd1) : al_hr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= RUN;
      buzz     <= 1'b0;
      sec      <= 7'd0;
      min      <= 7'd0;
      hr       <= 7'd0;
      al_min   <= 7'd0;
      al_hr    <= 7'd0;
      ring_cnt <= 6'd0;
      snz_cnt  <= 6'd0;
    end else begin
      case (st)
        RUN: begin
          if (set_time) begin
            st  <= SET_TIME;
            sec <= 7'd0;
          end else begin
            sec <= sec_nx;
            min <= min_nx;
            hr  <= hr_nx;
            if (set_alarm) begin
              st <= SET_ALARM;
            end else if (match) begin
              st       <= RING;
              buzz     <= 1'b1;
              ring_cnt <= 6'd0;
            end
          end
        end
        SET_TIME: begin
          sec <= 7'd0;
          min <= min_adv;
          hr  <= hr_adv;
          if (!set_time) st <= RUN;
        end
        SET_ALARM: begin
          sec    <= sec_nx;
          min    <= min_nx;
          hr     <= hr_nx;
          al_min <= al_min_adv;
          al_hr  <= al_hr_adv;
          if (!set_alarm) st <= RUN;
        end
        RING: begin
          sec <= sec_nx;
          min <= min_nx;
          hr  <= hr_nx;
          if (stop || !alarm_on) begin
            st   <= RUN;
            buzz <= 1'b0;
          end else if (snooze) begin
            st      <= SNOOZE;
            buzz    <= 1'b0;
            snz_cnt <= SNZ_LOAD;
          end else if (tick) begin
            if (ring_cnt == 6'd59) begin
              st       <= RUN;
              buzz     <= 1'b0;
              ring_cnt <= 6'd0;
            end else begin
              ring_cnt <= ring_cnt + 6'd1;
            end
          end
        end
        SNOOZE: begin
          sec <= sec_nx;
          min <= min_nx;
          hr  <= hr_nx;
          if (stop || !alarm_on) begin
            st <= RUN;
          end else if (min_roll) begin
            if (snz_cnt <= 6'd1) begin
              st       <= RING;
              buzz     <= 1'b1;
              ring_cnt <= 6'd0;
              snz_cnt  <= 6'd0;
            end else begin
              snz_cnt <= snz_cnt - 6'd1;
            end
          end
        end
        default: begin
          st   <= RUN;
          buzz <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed testbench for alarm_ctrl: timekeeping carries, set modes, ring,
// snooze, priorities and asynchronous reset.
module tb_alarm_ctrl;

  logic       clk, rst, tick, set_time, set_alarm, adv_min, adv_hr;
  logic       alarm_on, snooze, stop;
  logic [6:0] sec, min, hr, al_min, al_hr;
  logic       buzz;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // {state, buzz, hr, min, sec}
  logic [24:0] obs, exp_v;

  alarm_ctrl #(.HRS(24), .SNOOZE_MIN(9)) dut (
    .clk(clk), .rst(rst), .tick(tick), .set_time(set_time),
    .set_alarm(set_alarm), .adv_min(adv_min), .adv_hr(adv_hr),
    .alarm_on(alarm_on), .snooze(snooze), .stop(stop),
    .sec(sec), .min(min), .hr(hr), .al_min(al_min), .al_hr(al_hr),
    .buzz(buzz), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    step();
  endtask

  task automatic set_clock(input int h, input int m, input int s);
    pulse_reset();
    set_time = 1'b1;
    step();
    adv_hr = 1'b1;
    for (int i = 0; i < h; i++) step();
    adv_hr  = 1'b0;
    adv_min = 1'b1;
    for (int i = 0; i < m; i++) step();
    adv_min  = 1'b0;
    set_time = 1'b0;
    step();
    do_ticks(s);
  endtask

  task automatic set_alarm_time(input int h, input int m);
    set_alarm = 1'b1;
    step();
    adv_hr = 1'b1;
    for (int i = 0; i < h; i++) step();
    adv_hr  = 1'b0;
    adv_min = 1'b1;
    for (int i = 0; i < m; i++) step();
    adv_min   = 1'b0;
    set_alarm = 1'b0;
    step();
  endtask

  task automatic enter_ring();
    set_clock(7, 29, 59);
    set_alarm_time(7, 30);
    alarm_on = 1'b1;
    do_ticks(1);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({state, buzz, hr, min, sec, al_hr, al_min} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_state: got st=%0d bz=%0b %0d:%0d:%0d al=%0d:%0d want all 0",
               state, buzz, hr, min, sec, al_hr, al_min);
    end
    #4 rst = 1'b1;
    step(); step();
    obs = {state, buzz, hr, min, sec};
    n_cmp++;
    if (obs !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want 0", obs);
    end
    do_ticks(1);
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd0, 1'b0, 7'd0, 7'd0, 7'd1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL first_tick: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_rollover();
    set_clock(0, 59, 58);
    do_ticks(1);
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd0, 1'b0, 7'd0, 7'd59, 7'd59};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL roll_005959: got %h want %h", obs, exp_v);
    end
    do_ticks(1);
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd0, 1'b0, 7'd1, 7'd0, 7'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL roll_010000: got %h want %h", obs, exp_v);
    end
    set_clock(23, 59, 59);
    do_ticks(1);
    obs = {state, buzz, hr, min, sec};
    exp_v = 25'd0;
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL roll_day: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_set_time();
    pulse_reset();
    do_ticks(5);
    set_time = 1'b1;
    tick     = 1'b1;
    step();
    adv_min = 1'b1;
    for (int i = 0; i < 61; i++) step();
    adv_min = 1'b0;
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd1, 1'b0, 7'd0, 7'd1, 7'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL set_min_wrap: got %h want %h", obs, exp_v);
    end
    adv_hr = 1'b1;
    for (int i = 0; i < 25; i++) step();
    adv_hr = 1'b0;
    step(); step();
    tick = 1'b0;
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd1, 1'b0, 7'd1, 7'd1, 7'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL set_hr_wrap: got %h want %h", obs, exp_v);
    end
    set_time = 1'b0;
    step();
    do_ticks(3);
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd0, 1'b0, 7'd1, 7'd1, 7'd3};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL set_resume: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_alarm_ring();
    enter_ring();
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd3, 1'b1, 7'd7, 7'd30, 7'd0};
    n_cmp++;
    if (obs !== exp_v || al_hr !== 7'd7 || al_min !== 7'd30) begin
      n_bad++;
      $display("FAIL ring_entry: got %h al=%0d:%0d want %h al=7:30",
               obs, al_hr, al_min, exp_v);
    end
    do_ticks(59);
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd3, 1'b1, 7'd7, 7'd30, 7'd59};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL ring_hold59: got %h want %h", obs, exp_v);
    end
    do_ticks(1);
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd0, 1'b0, 7'd7, 7'd31, 7'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL ring_timeout: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_snooze();
    enter_ring();
    snooze = 1'b1;
    stop   = 1'b1;
    step();
    snooze = 1'b0;
    stop   = 1'b0;
    n_cmp++;
    if ({state, buzz} !== {3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL stop_beats_snooze: got st=%0d bz=%0b want st=0 bz=0", state, buzz);
    end
    enter_ring();
    set_time = 1'b1;
    step();
    set_time = 1'b0;
    n_cmp++;
    if ({state, buzz} !== {3'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL ring_ignore_set: got st=%0d bz=%0b want st=3 bz=1", state, buzz);
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    n_cmp++;
    if ({state, buzz} !== {3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL snooze_entry: got st=%0d bz=%0b want st=4 bz=0", state, buzz);
    end
    do_ticks(539);
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd4, 1'b0, 7'd7, 7'd38, 7'd59};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL snooze_hold: got %h want %h", obs, exp_v);
    end
    do_ticks(1);
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd3, 1'b1, 7'd7, 7'd39, 7'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL snooze_rering: got %h want %h", obs, exp_v);
    end
    snooze = 1'b1;
    step();
    snooze   = 1'b0;
    alarm_on = 1'b0;
    step();
    n_cmp++;
    if ({state, buzz} !== {3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL snooze_disarm: got st=%0d bz=%0b want st=0 bz=0", state, buzz);
    end
  endtask

  task automatic test_priority();
    pulse_reset();
    set_time  = 1'b1;
    set_alarm = 1'b1;
    step();
    n_cmp++;
    if (state !== 3'd1) begin
      n_bad++;
      $display("FAIL set_priority: got st=%0d want 1", state);
    end
    set_time  = 1'b0;
    set_alarm = 1'b0;
    step();
    alarm_on = 1'b0;
    set_clock(7, 29, 59);
    set_alarm_time(7, 30);
    do_ticks(1);
    obs = {state, buzz, hr, min, sec};
    exp_v = {3'd0, 1'b0, 7'd7, 7'd30, 7'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL disarmed_match: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_ring();
    enter_ring();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({state, buzz, hr, min, sec, al_hr, al_min} !== 39'd0) begin
      n_bad++;
      $display("FAIL async_reset_ring: got st=%0d bz=%0b %0d:%0d:%0d al=%0d:%0d want all 0",
               state, buzz, hr, min, sec, al_hr, al_min);
    end
    rst      = 1'b1;
    alarm_on = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; set_time = 1'b0; set_alarm = 1'b0;
    adv_min = 1'b0; adv_hr = 1'b0; alarm_on = 1'b0; snooze = 1'b0; stop = 1'b0;
    test_reset();
    test_rollover();
    test_set_time();
    test_alarm_ring();
    test_snooze();
    test_priority();
    test_reset_ring();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter HRS, default 24, hour modulus (hours count 0..HRS-1).
REQ-002 Parameter SNOOZE_MIN, default 9, snooze length in minute rollovers (1..60).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  one-cycle pulse, once per second.
REQ-006 set_time  input  1  level; high requests time-set mode.
REQ-007 set_alarm  input  1  level; high requests alarm-set mode.
REQ-008 adv_min  input  1  advance minute field by 1 per cycle high (set modes only).
REQ-009 adv_hr  input  1  advance hour field by 1 per cycle high (set modes only).
REQ-010 alarm_on  input  1  level; alarm armed when high.
REQ-011 snooze  input  1  one-cycle pulse; snooze request.
REQ-012 stop  input  1  one-cycle pulse; silence alarm.
REQ-013 sec, min, hr  output  7 each  current time, registered.
REQ-014 al_min, al_hr  output  7 each  alarm time, registered.
REQ-015 buzz  output  1  high exactly while state is RING.
REQ-016 state  output  3  encoding RUN=0, SET_TIME=1, SET_ALARM=2, RING=3, SNOOZE=4.

Function
REQ-017 Timekeeping (RUN, SET_ALARM, RING, SNOOZE): tick increments sec mod 60; sec==59 with tick increments min mod 60; min==59 and sec==59 with tick increments hr mod HRS; all carries in the same cycle.
REQ-018 Arithmetic is 7-bit, wrap via compare-to-limit; fields never exceed 59/HRS-1.
REQ-019 RUN -> SET_TIME when set_time high; else RUN -> SET_ALARM when set_alarm high (set_time has priority).
REQ-020 SET_TIME: tick ignored; sec forced to 0 on entry and held; adv_min increments min mod 60 with no carry into hr; adv_hr increments hr mod HRS; both in same cycle both apply.
REQ-021 SET_TIME -> RUN the cycle after set_time low; counting resumes from sec=0.
REQ-022 SET_ALARM: time keeps running; adv_min/adv_hr modify al_min/al_hr with same wrap rules; exit to RUN when set_alarm low; no alarm match evaluated in this state.
REQ-023 Alarm match: in RUN with alarm_on high, a tick whose result is sec==0, min==al_min, hr==al_hr moves state to RING next cycle together with the time update.
REQ-024 RING: ring counter cleared on entry, increments per tick; at 60 ticks -> RUN.
REQ-025 RING: stop or alarm_on low -> RUN; else snooze -> SNOOZE, loading snooze counter with SNOOZE_MIN; stop beats snooze when simultaneous.
REQ-026 SNOOZE: snooze counter decrements on each minute rollover (REQ-017); reaching 0 -> RING; stop or alarm_on low -> RUN.
REQ-027 set_time, set_alarm, adv_min, adv_hr ignored in RING and SNOOZE.
REQ-028 Undefined state encodings recover to RUN next cycle.

Reset
REQ-029 rst low asynchronously forces sec=min=hr=0, al_min=al_hr=0, state=RUN, buzz=0, ring and snooze counters 0; mid-ring reset silences buzz immediately.
REQ-030 First counting occurs on the first tick sampled after rst deasserts.

Verification
REQ-031 Time 00:59:58, two ticks -> 00:59:59 then 01:00:00; at 23:59:59 one tick -> 00:00:00 (HRS=24).
REQ-032 set_time high, adv_min x61, adv_hr x25, ticks applied -> min=1, hr=1, sec=0, no count; set_time low, 3 ticks -> sec=3.
REQ-033 Alarm 07:30, alarm_on=1, time 07:29:59, tick -> 07:30:00, state=RING, buzz=1; no response, 60 ticks -> RUN, buzz=0.
REQ-034 In RING pulse snooze and stop same cycle -> RUN; separately snooze alone, 9 minute rollovers -> RING again at 07:39:00 (tick count per REQ-026).
REQ-035 set_time and set_alarm high together in RUN -> SET_TIME; alarm match time reached with alarm_on=0 -> stays RUN.
REQ-036 rst pulsed low mid-RING, between clock edges -> outputs zero and buzz=0 without a clock edge.
